// File: rtl/rsa_mont_exp_ctrl_if.sv
// Request/result and Montgomery-product-unit signals of the modular exponentiation controller.
// master = controller side, slave = RSA top FSM plus product unit.
interface rsa_mont_exp_ctrl_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] y_mont;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] result;
    logic             finish;
    logic             mp_start;
    logic [WIDTH-1:0] mp_N;
    logic [WIDTH-1:0] mp_a;
    logic [WIDTH-1:0] mp_b;
    logic [WIDTH-1:0] mp_m;
    logic             mp_finish;

    modport master (
        input  start, N, y_mont, d, mp_m, mp_finish,
        output result, finish, mp_start, mp_N, mp_a, mp_b
    );

    modport slave (
        output start, N, y_mont, d, mp_m, mp_finish,
        input  result, finish, mp_start, mp_N, mp_a, mp_b
    );
endinterface

// File: rtl/rsa_mont_exp_ctrl.sv
// Right-to-left square-and-multiply y^d mod N over the Montgomery product unit; finish after (W+1)+(W+2)*(W+popcount(d)) cycles.
// No backpressure: start is only sampled in IDLE, and each product op waits for mp_finish low-then-high.
module rsa_mont_exp_ctrl #(
    parameter int WIDTH = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    rsa_mont_exp_ctrl_if.master bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int IW = BW + 1;

    typedef enum logic [2:0] {
        IDLE, CHECK, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] n_r_q, d_r_q, m_q, t_q;
    logic [IW-1:0]    i_q;
    logic             seen_low_q;
    logic [WIDTH-1:0] result_q;
    logic             finish_q;
    logic             mp_start_q;
    logic [WIDTH-1:0] mp_n_q, mp_a_q, mp_b_q;

    logic mp_done_d;
    logic last_bit_d;
    logic exp_bit_d;

    // mp_finish idles high, so a capture is only legal once the low phase of this op was observed.
    assign mp_done_d  = bus.mp_finish & seen_low_q;
    assign last_bit_d = (i_q == IW'(WIDTH - 1));
    assign exp_bit_d  = d_r_q[i_q[BW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_r_q      <= '0;
            d_r_q      <= '0;
            m_q        <= '0;
            t_q        <= '0;
            i_q        <= '0;
            seen_low_q <= 1'b0;
            result_q   <= '0;
            finish_q   <= 1'b0;
            mp_start_q <= 1'b0;
            mp_n_q     <= '0;
            mp_a_q     <= '0;
            mp_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_r_q   <= bus.N;
                        d_r_q   <= bus.d;
                        t_q     <= bus.y_mont;
                        m_q     <= WIDTH'(1);
                        i_q     <= '0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    mp_start_q <= 1'b1;
                    mp_n_q     <= n_r_q;
                    mp_b_q     <= t_q;
                    if (exp_bit_d) begin
                        mp_a_q  <= m_q;
                        state_q <= MUL_ISSUE;
                    end else begin
                        mp_a_q  <= t_q;
                        state_q <= SQR_ISSUE;
                    end
                end
                MUL_ISSUE: begin
                    mp_start_q <= 1'b0;
                    seen_low_q <= 1'b0;
                    state_q    <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (!bus.mp_finish) begin
                        seen_low_q <= 1'b1;
                    end
                    if (mp_done_d) begin
                        m_q        <= bus.mp_m;
                        mp_start_q <= 1'b1;
                        mp_a_q     <= t_q;
                        mp_b_q     <= t_q;
                        state_q    <= SQR_ISSUE;
                    end
                end
                SQR_ISSUE: begin
                    mp_start_q <= 1'b0;
                    seen_low_q <= 1'b0;
                    state_q    <= SQR_WAIT;
                end
                SQR_WAIT: begin
                    if (!bus.mp_finish) begin
                        seen_low_q <= 1'b1;
                    end
                    if (mp_done_d) begin
                        t_q <= bus.mp_m;
                        if (last_bit_d) begin
                            // m is already final here; publishing it now aligns result with the finish pulse.
                            result_q <= m_q;
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            i_q     <= i_q + IW'(1);
                            state_q <= CHECK;
                        end
                    end
                end
                DONE: begin
                    finish_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.finish   = finish_q;
    assign bus.mp_start = mp_start_q;
    assign bus.mp_N     = mp_n_q;
    assign bus.mp_a     = mp_a_q;
    assign bus.mp_b     = mp_b_q;
endmodule

// File: tb/tb_rsa_mont_exp_ctrl.sv
// Bench for rsa_mont_exp_ctrl at WIDTH=8 with a behavioural Montgomery product unit (latency WIDTH+1).
module tb_rsa_mont_exp_ctrl;
    localparam int W = 8;
    localparam int L = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsa_mont_exp_ctrl_if #(.WIDTH(W)) bus ();
    rsa_mont_exp_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
        longint p;
        p = longint'(a) * longint'(b);
        for (int k = 0; k < W; k++) begin
            if (p[0]) p = p + longint'(n);
            p = p >> 1;
        end
        if (p >= longint'(n)) p = p - longint'(n);
        return W'(p);
    endfunction

    function automatic logic [W-1:0] modpow(input int y, input int e, input int n);
        longint r, b;
        r = 1 % n;
        b = y % n;
        for (int k = 0; k < W; k++) begin
            if (e[k]) r = (r * b) % n;
            b = (b * b) % n;
        end
        return W'(r);
    endfunction

    // Behavioural product unit: mp_finish optionally stays high hold_extra cycles after sampling.
    int hold_extra = 0;
    logic busy;
    int cnt;
    logic [W-1:0] mres;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= 0;
            mres <= '0;
        end else if (!busy && bus.mp_start) begin
            busy <= 1'b1;
            cnt  <= 1;
            mres <= mont(bus.mp_a, bus.mp_b, bus.mp_N);
        end else if (busy) begin
            if (cnt == L) busy <= 1'b0;
            else cnt <= cnt + 1;
        end
    end
    assign bus.mp_finish = !busy || (cnt <= hold_extra) || (cnt == L);
    assign bus.mp_m      = mres;

    typedef struct {
        logic [W-1:0] res;
        int           t0;
        int           lat;
        int           pulses;
        bit           chk_first;
        logic [W-1:0] fa;
        logic [W-1:0] fb;
    } exp_t;
    exp_t sb[$];

    int mp_pulses = 0;
    bit first_op = 1'b0;
    logic [W-1:0] first_a, first_b, op_a, op_b, op_n, last_res;
    logic prev_start = 1'b0;
    logic prev_fin = 1'b0;
    int stray = 0;
    int fin_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mp_start) begin
                mp_pulses++;
                chk("mp_start_consecutive", prev_start, 1'b0);
                chk("mp_start_while_busy", busy, 1'b0);
                op_a = bus.mp_a;
                op_b = bus.mp_b;
                op_n = bus.mp_N;
                if (first_op) begin
                    first_a  = bus.mp_a;
                    first_b  = bus.mp_b;
                    first_op = 1'b0;
                end
            end else if (busy) begin
                chk("op_stable_a", bus.mp_a, op_a);
                chk("op_stable_b", bus.mp_b, op_b);
                chk("op_stable_n", bus.mp_N, op_n);
            end
            if (prev_fin) begin
                chk("finish_one_cycle", bus.finish, 1'b0);
                chk("result_hold", bus.result, last_res);
            end
            if (bus.finish) begin
                exp_t e;
                fin_seen++;
                last_res = bus.result;
                if (sb.size() == 0) begin
                    stray++;
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("latency", cyc - e.t0, e.lat);
                    chk("mp_pulses", mp_pulses, e.pulses);
                    if (e.chk_first) begin
                        chk("first_mp_a", first_a, e.fa);
                        chk("first_mp_b", first_b, e.fb);
                    end
                end
            end
            prev_start = bus.mp_start;
            prev_fin   = bus.finish;
        end else begin
            prev_start = 1'b0;
            prev_fin   = 1'b0;
        end
    end

    task automatic run(input int n, input int y, input int e, input bit chk_first);
        exp_t x;
        @(negedge clk);
        bus.N      = W'(n);
        bus.y_mont = W'((y * (1 << W)) % n);
        bus.d      = W'(e);
        bus.start  = 1'b1;
        x.res       = modpow(y, e, n);
        x.t0        = cyc;
        x.lat       = (W + 1) + (W + 2) * (W + $countones(W'(e)));
        x.pulses    = W + $countones(W'(e));
        x.chk_first = chk_first;
        x.fa        = W'(1);
        x.fb        = W'((y * (1 << W)) % n);
        sb.push_back(x);
        mp_pulses = 0;
        first_op  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("completion_timeout", sb.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_result"}, bus.result, '0);
        chk({tag, "_finish"}, bus.finish, 1'b0);
        chk({tag, "_mp_start"}, bus.mp_start, 1'b0);
        chk({tag, "_mp_N"}, bus.mp_N, '0);
        chk({tag, "_mp_a"}, bus.mp_a, '0);
        chk({tag, "_mp_b"}, bus.mp_b, '0);
    endtask

    initial begin
        int fin_before;
        bus.start  = 1'b0;
        bus.N      = '0;
        bus.y_mont = '0;
        bus.d      = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_finish", bus.finish, 1'b0);
        chk("idle_mp_start", bus.mp_start, 1'b0);

        // Basic, zero, unit, all-ones exponent and zero base.
        run(77, 5, 7, 1'b0);
        wait_done(400);
        chk("basic_literal_47", last_res, 8'd47);
        run(77, 5, 0, 1'b0);
        wait_done(400);
        chk("zero_exp_literal_1", last_res, 8'd1);
        run(77, 5, 1, 1'b1);
        wait_done(400);
        chk("unit_exp_literal_5", last_res, 8'd5);
        run(251, 200, 255, 1'b1);
        wait_done(400);
        run(77, 0, 5, 1'b0);
        wait_done(400);

        // Product unit leaves mp_finish high for 3 cycles after sampling mp_start.
        hold_extra = 3;
        run(77, 5, 7, 1'b0);
        wait_done(400);
        run(91, 10, 13, 1'b1);
        wait_done(400);
        hold_extra = 0;

        // Start with different operands while busy is ignored.
        run(77, 5, 7, 1'b0);
        repeat (30) @(negedge clk);
        bus.N      = 8'd91;
        bus.y_mont = 8'd17;
        bus.d      = 8'd200;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(400);
        run(91, 10, 200, 1'b0);
        wait_done(400);

        // Mid-run reset aborts with no finish pulse.
        run(251, 7, 255, 1'b0);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        chk_outputs_zero("midreset_hold");
        sb.delete();
        fin_before = fin_seen;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_finish_after_reset", fin_seen - fin_before, 0);
        run(77, 5, 7, 1'b0);
        wait_done(400);
        chk("post_reset_literal_47", last_res, 8'd47);

        chk("scoreboard_empty", sb.size(), 0);
        chk("stray_finish", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
